// File: rtl/systolic_array.sv
// ---------------------------------------------------------------------------
// systolic_array
//
// Output-stationary N x N matrix-multiply grid. Row operands (a-lane) travel
// left to right, column operands (b-lane) travel top to bottom, one PE per
// cycle. Each PE multiplies the operands it sees and accumulates the unsigned
// product locally. Accumulators wrap and only clear on rst.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears every PE register
//   en         : global advance enable; when low every register holds
//   in_left    : [N] row operands, in_left[i] enters PE[i][0]
//   in_top     : [N] column operands, in_top[j] enters PE[0][j]
//   out_right  : [N] registered a-lane leaving PE[i][N-1]
//   out_bottom : [N] registered b-lane leaving PE[N-1][j]
//   acc_out    : [N][N] accumulator of each PE, straight from its register
// ---------------------------------------------------------------------------
module systolic_array #(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in_left    [MATRIX_SIZE],
    input  logic [DATA_WIDTH-1:0] in_top     [MATRIX_SIZE],
    output logic [DATA_WIDTH-1:0] out_right  [MATRIX_SIZE],
    output logic [DATA_WIDTH-1:0] out_bottom [MATRIX_SIZE],
    output logic [ACC_WIDTH-1:0]  acc_out    [MATRIX_SIZE][MATRIX_SIZE]
);

    localparam int N = MATRIX_SIZE;

    logic [DATA_WIDTH-1:0] a_q   [N][N];
    logic [DATA_WIDTH-1:0] a_d   [N][N];
    logic [DATA_WIDTH-1:0] b_q   [N][N];
    logic [DATA_WIDTH-1:0] b_d   [N][N];
    logic [ACC_WIDTH-1:0]  acc_q [N][N];
    logic [ACC_WIDTH-1:0]  acc_d [N][N];

    // Operand seen by each PE this cycle (from the array edge or a neighbour).
    logic [DATA_WIDTH-1:0] a_in  [N][N];
    logic [DATA_WIDTH-1:0] b_in  [N][N];

    // Unsigned product zero-extended into the accumulator; sum wraps.
    function automatic logic [ACC_WIDTH-1:0] mac(
        input logic [ACC_WIDTH-1:0]  acc,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] prod;
        prod = a * b;
        return acc + ACC_WIDTH'(prod);
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = in_left[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_q[i][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            b_in[0][j] = in_top[j];
            for (int i = 1; i < N; i++) begin
                b_in[i][j] = b_q[i-1][j];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_d[i][j]   = a_q[i][j];
                b_d[i][j]   = b_q[i][j];
                acc_d[i][j] = acc_q[i][j];
                if (en) begin
                    a_d[i][j]   = a_in[i][j];
                    b_d[i][j]   = b_in[i][j];
                    acc_d[i][j] = mac(acc_q[i][j], a_in[i][j], b_in[i][j]);
                end
            end
        end
    end

    // Reset clears operands as well as sums so in-flight data is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_q[i][j]   <= a_d[i][j];
                    b_q[i][j]   <= b_d[i][j];
                    acc_q[i][j] <= acc_d[i][j];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            out_right[k]  = a_q[k][N-1];
            out_bottom[k] = b_q[N-1][k];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc_out[i][j] = acc_q[i][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// ---------------------------------------------------------------------------
// tb_systolic_array
//
// Directed bench for systolic_array: a 3x3 instance with 8-bit operands and
// 32-bit accumulators, plus a 1x1 instance with 16-bit accumulators for the
// wrap-around case. Both share clk and rst.
// ---------------------------------------------------------------------------
module tb_systolic_array;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in_left    [3];
    logic [7:0] in_top     [3];
    logic [7:0] out_right  [3];
    logic [7:0] out_bottom [3];
    logic [31:0] acc_out   [3][3];

    logic        en1;
    logic [7:0]  in_left1    [1];
    logic [7:0]  in_top1     [1];
    logic [7:0]  out_right1  [1];
    logic [7:0]  out_bottom1 [1];
    logic [15:0] acc_out1    [1][1];

    int checks = 0;
    int errors = 0;

    int A [3][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    int B [3][3] = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};
    int C [3][3] = '{'{30, 24, 18}, '{84, 69, 54}, '{138, 114, 90}};

    systolic_array #(.MATRIX_SIZE(3), .DATA_WIDTH(8), .ACC_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_left    (in_left),
        .in_top     (in_top),
        .out_right  (out_right),
        .out_bottom (out_bottom),
        .acc_out    (acc_out)
    );

    systolic_array #(.MATRIX_SIZE(1), .DATA_WIDTH(8), .ACC_WIDTH(16)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en1),
        .in_left    (in_left1),
        .in_top     (in_top1),
        .out_right  (out_right1),
        .out_bottom (out_bottom1),
        .acc_out    (acc_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge; returns 1 time unit later so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Partial sum of C[i][j] after e enabled edges of the skewed stream.
    function automatic int partial(input int i, input int j, input int e);
        int s = 0;
        for (int k = 0; k < 3; k++) begin
            if (i + j + k < e) s += A[i][k] * B[k][j];
        end
        return s;
    endfunction

    task automatic drive_skew(input int t);
        for (int i = 0; i < 3; i++) begin
            in_left[i] = (t - i >= 0 && t - i < 3) ? 8'(A[i][t-i]) : 8'd0;
            in_top[i]  = (t - i >= 0 && t - i < 3) ? 8'(B[t-i][i]) : 8'd0;
        end
    endtask

    task automatic set_inputs(input int v);
        for (int k = 0; k < 3; k++) begin
            in_left[k] = 8'(v);
            in_top[k]  = 8'(v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_right"}, out_right[k], 0);
            chk({tag, "_bottom"}, out_bottom[k], 0);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                chk({tag, "_acc"}, acc_out[i][j], 0);
    endtask

    task automatic chk_partial(input string tag, input int e);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                chk(tag, acc_out[i][j], partial(i, j, e));
    endtask

    task automatic chk_product(input string tag);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                chk(tag, acc_out[i][j], C[i][j]);
    endtask

    initial begin
        // Reset with nonzero inputs and enable low.
        rst = 1'b1;
        en  = 1'b0;
        en1 = 1'b0;
        set_inputs(7);
        in_left1[0] = 8'd7;
        in_top1[0]  = 8'd7;
        tick();
        tick();
        chk_all_zero("reset");
        chk("reset_acc1", acc_out1[0][0], 0);
        chk("reset_right1", out_right1[0], 0);

        // Single unskewed pulse: only the diagonal meets.
        rst = 1'b0;
        en  = 1'b1;
        in_left1[0] = 8'd0;
        in_top1[0]  = 8'd0;
        for (int k = 0; k < 3; k++) begin
            in_left[k] = 8'(k + 1);
            in_top[k]  = 8'(k + 4);
        end
        tick();
        chk("pulse_acc00_e1", acc_out[0][0], 4);
        set_inputs(0);
        tick();
        for (int k = 0; k < 3; k++) chk("pulse_right_e2", out_right[k], 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("pulse_right_e3", out_right[k], k + 1);
            chk("pulse_bottom_e3", out_bottom[k], k + 4);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("pulse_right_e4", out_right[k], 0);
            chk("pulse_bottom_e4", out_bottom[k], 0);
        end
        for (int c = 0; c < 20; c++) tick();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                chk("pulse_acc", acc_out[i][j], (i == j) ? (i + 1) * (i + 4) : 0);

        // Skewed 3x3 multiply.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 7; t++) begin
            drive_skew(t);
            tick();
            if (t == 3) chk_partial("skew_partial_e4", 4);
        end
        set_inputs(0);
        chk_product("skew_result");
        tick();
        tick();
        chk_product("skew_hold");

        // Same stream with a two-cycle stall after three edges.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 7; t++) begin
            drive_skew(t);
            if (t == 3) begin
                en = 1'b0;
                tick();
                chk_partial("stall_1", 3);
                tick();
                chk_partial("stall_2", 3);
                en = 1'b1;
            end
            tick();
        end
        set_inputs(0);
        chk_product("stall_result");

        // Reset in the middle of a stream, then rerun.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive_skew(t);
            tick();
        end
        chk_partial("midrst_before", 4);
        rst = 1'b1;
        drive_skew(4);
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        for (int t = 0; t < 7; t++) begin
            drive_skew(t);
            tick();
        end
        set_inputs(0);
        chk_product("midrst_rerun");

        // Accumulator wrap on the 1x1, 16-bit instance.
        en = 1'b0;
        en1 = 1'b1;
        in_left1[0] = 8'd255;
        in_top1[0]  = 8'd255;
        tick();
        chk("wrap_e1", acc_out1[0][0], 65025);
        chk("wrap_right1", out_right1[0], 255);
        tick();
        en1 = 1'b0;
        chk("wrap_e2", acc_out1[0][0], 64514);
        tick();
        chk("wrap_hold", acc_out1[0][0], 64514);
        chk_product("disabled_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
